cnn_result_collector: RTL and testbench
=======================================

# cnn_result_collector

Consumer end of the CNN output interface. Captures each 16-lane result vector that the `cnn` core presents on `result_en`, and buffers it in a small vector FIFO. Serializes the buffered vectors as a single 32-bit valid/ready stream tagged with lane and pixel index, for downstream storage or a host link. The `cnn` core has no backpressure, so the collector must absorb bursts and flag any loss.

## Interface
Parameters:
- `DATA_W`, 32: width of one result word
- `LANES`, 16: result words per vector (one per conv kernel)
- `DEPTH`, 4: vector FIFO depth, power of two, ≥2
- `NPIX`, 676: result vectors per frame (26×26 for 3×3 valid conv on 28×28)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `result_en`  in  1  vector valid strobe from `cnn`, one cycle per vector
- `result_vec`  in  LANES*DATA_W  lane k at bits [k*DATA_W +: DATA_W]
- `out_valid`  out  1  stream word valid
- `out_ready`  in  1  downstream accept
- `out_data`  out  DATA_W  current word
- `out_lane`  out  $clog2(LANES)  lane index of `out_data`
- `out_pix`  out  $clog2(NPIX)  pixel index of the current vector
- `out_last`  out  1  high on lane LANES-1 of pixel NPIX-1
- `frame_done`  out  1  one-cycle pulse after the `out_last` word transfers
- `overflow`  out  1  sticky: a vector was dropped
- `level`  out  $clog2(DEPTH)+1  vectors currently buffered

## Operation
- Push: a vector is written to the FIFO tail when `result_en` is high and the FIFO is not full, or when it is full but a pop happens in the same cycle.
- Drop: a vector arriving while the FIFO is full with no same-cycle pop is discarded. `overflow` is set and held until `rst`. Pixel numbering does not advance for a dropped vector.
- Serializer: `out_valid` = FIFO not empty. `out_data` = head vector lane `lane_cnt`.
- Transfer: a word transfers when `out_valid && out_ready`, and `lane_cnt` increments.
  - On transfer at `lane_cnt == LANES-1`: pop the head, set `lane_cnt` to 0, and increment `pix_cnt`.
  - `pix_cnt` wraps NPIX-1 → 0.
- `out_last` = `out_valid && lane_cnt==LANES-1 && pix_cnt==NPIX-1`.
- `frame_done` is registered and asserted the cycle after the `out_last` transfer.
- Push and pop in the same cycle: `level` is unchanged, and both pointers advance modulo DEPTH.
- Reset values: `out_valid` 0, `out_lane` 0, `out_pix` 0, `out_last` 0, `frame_done` 0, `overflow` 0, `level` 0. Reset mid-frame discards all buffered vectors and restarts numbering at pixel 0, lane 0. FIFO contents need not be cleared.

## Timing
- Capture latency: a vector strobed at edge t is visible with `out_valid`=1 after edge t (first cycle t+1), when the FIFO was empty.
- Steady state: one word per cycle with `out_ready` held high. A vector drains in LANES cycles, and the next vector's lane 0 follows without a bubble.
- Stability: while `out_valid && !out_ready`, `out_data`, `out_lane`, `out_pix` and `out_last` hold stable.
- Sustainable input rate without loss: one vector per LANES cycles. Faster bursts are absorbed up to DEPTH vectors.
- `level` and `overflow` are registered and update at the edge following the event.

## Structure
- Shared package `cnn_pkg`: `DATA_W`, `LANES`, `NPIX` constants and typedef `result_vec_t` (LANES×DATA_W packed).
- Sub-module `vec_fifo`: synchronous FIFO, width LANES*DATA_W, depth DEPTH. Interface: push, pop, full, empty, count, and the head vector, read combinationally from the register array.
- Top-level logic: lane/pixel counters, `out_*` muxing, drop/overflow logic, `frame_done` register.

## Test plan
- Single vector, lanes = 0x100+k, `out_ready`=1: 16 words 0x100…0x10F on lanes 0…15, `out_pix`=0, `out_valid` low afterward, `level` returns to 0.
- Backpressure: toggle `out_ready` 1,0,0,1… during drain: every word is seen exactly once, outputs are stable during stalls, and order is preserved.
- Burst: 6 vectors on consecutive cycles with `out_ready`=0 and DEPTH=4:
  - `level`=4 and `overflow`=1 after the 5th vector.
  - After releasing `out_ready`, exactly vectors 0–3 drain, with pixels 0–3.
- Full plus simultaneous pop: FIFO full, and `result_en` arrives in the same cycle as the lane-15 transfer. The vector is accepted, `overflow` stays 0, and `level` stays 4.
- Frame wrap with NPIX=4 and 5 vectors: `out_last` on pixel 3 lane 15, `frame_done` pulses one cycle later, and the 5th vector appears as pixel 0.
- Reset mid-drain: `rst` asserted at lane 7 of pixel 2 with 2 vectors buffered. Next cycle `out_valid`=0, `level`=0, `overflow`=0. A new vector then streams as pixel 0, lane 0.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN result path.
//   DATA_W       : width of one result word
//   LANES        : result words per vector (one per conv kernel)
//   NPIX         : result vectors per frame (26x26 valid conv on 28x28)
//   DEPTH        : default depth of the collector's vector FIFO
//   result_vec_t : one result vector, lane k in element [k]
package cnn_pkg;

  localparam int DATA_W = 32;
  localparam int LANES  = 16;
  localparam int NPIX   = 676;
  localparam int DEPTH  = 4;

  typedef logic [LANES-1:0][DATA_W-1:0] result_vec_t;

endpackage

// File: rtl/vec_fifo.sv
// Synchronous vector FIFO with a combinational head read.
//   clk, rst : clock and synchronous active-high reset
//   push     : write wdata at the tail (caller guarantees !full or same-cycle pop)
//   wdata    : vector to write
//   pop      : drop the head (caller guarantees !empty)
//   full     : DEPTH entries held
//   empty    : no entries held
//   count    : number of entries held
//   head     : oldest entry, read straight from the register array
module vec_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two. A push into a
  // full FIFO only happens together with a pop, so the write lands on the
  // slot being vacated and the count stays put.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; stale contents are never visible because
  // empty gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/cnn_result_collector.sv
// Consumer end of the CNN output interface. Captures each LANES-wide result
// vector strobed by the cnn core, buffers it in a small vector FIFO and
// serializes it as one DATA_W word per transfer, tagged with lane and pixel.
//   clk, rst   : clock and synchronous active-high reset
//   result_en  : one-cycle vector strobe from cnn (no backpressure)
//   result_vec : lane k at bits [k*DATA_W +: DATA_W]
//   out_valid  : stream word valid (FIFO not empty)
//   out_ready  : downstream accept
//   out_data   : current word (head vector, lane out_lane)
//   out_lane   : lane index of out_data
//   out_pix    : pixel index of the head vector
//   out_last   : last lane of the last pixel in the frame
//   frame_done : one-cycle pulse after the out_last word transfers
//   overflow   : sticky, a vector was dropped because the FIFO was full
//   level      : vectors currently buffered
module cnn_result_collector #(
  parameter int DATA_W = cnn_pkg::DATA_W,
  parameter int LANES  = cnn_pkg::LANES,
  parameter int DEPTH  = cnn_pkg::DEPTH,
  parameter int NPIX   = cnn_pkg::NPIX,
  localparam int LW = $clog2(LANES),
  localparam int PW = $clog2(NPIX),
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int VW = LANES * DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              result_en,
  input  logic [VW-1:0]     result_vec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [LW-1:0]     out_lane,
  output logic [PW-1:0]     out_pix,
  output logic              out_last,
  output logic              frame_done,
  output logic              overflow,
  output logic [CW-1:0]     level
);

  logic              fifo_full;
  logic              fifo_empty;
  logic [VW-1:0]     head_vec;
  logic [DATA_W-1:0] head_lanes [LANES];
  logic [LW-1:0]     lane_cnt;
  logic [PW-1:0]     pix_cnt;
  logic              xfer;
  logic              lane_end;
  logic              pix_end;
  logic              pop;
  logic              push;
  logic              drop;

  // A vector may enter a full FIFO only when the head leaves in the same
  // cycle; otherwise it is lost and overflow latches.
  assign out_valid = !fifo_empty;
  assign xfer      = out_valid && out_ready;
  assign lane_end  = (lane_cnt == LW'(LANES - 1));
  assign pix_end   = (pix_cnt == PW'(NPIX - 1));
  assign pop       = xfer && lane_end;
  assign push      = result_en && (!fifo_full || pop);
  assign drop      = result_en && fifo_full && !pop;

  vec_fifo #(
    .WIDTH (VW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (result_vec),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (level),
    .head  (head_vec)
  );

  // Split the head vector into lanes so the word select is a plain array index.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign head_lanes[k] = head_vec[k*DATA_W +: DATA_W];
  end

  assign out_data = head_lanes[lane_cnt];
  assign out_lane = lane_cnt;
  assign out_pix  = pix_cnt;
  assign out_last = out_valid && lane_end && pix_end;

  // Pixel numbering follows the output side, so a dropped vector never
  // consumes a pixel number.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_cnt <= '0;
      pix_cnt  <= '0;
    end else if (xfer) begin
      if (lane_end) begin
        lane_cnt <= '0;
        pix_cnt  <= pix_end ? '0 : pix_cnt + PW'(1);
      end else begin
        lane_cnt <= lane_cnt + LW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      overflow   <= overflow | drop;
      frame_done <= xfer && out_last;
    end
  end

endmodule

// File: tb/tb_cnn_result_collector.sv
// Self-checking bench for cnn_result_collector (DEPTH=4, NPIX=4).
// A scoreboard of expected words is filled whenever a vector should be
// accepted and consumed as words transfer; outputs are sampled on the
// falling edge.
module tb_cnn_result_collector;
  import cnn_pkg::*;

  localparam int T_DEPTH = 4;
  localparam int T_NPIX  = 4;
  localparam int LW = $clog2(LANES);
  localparam int PW = $clog2(T_NPIX);
  localparam int CW = $clog2(T_DEPTH) + 1;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                lane;
    int                pix;
    bit                last;
  } word_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              result_en;
  result_vec_t       result_vec;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [LW-1:0]     out_lane;
  logic [PW-1:0]     out_pix;
  logic              out_last;
  logic              frame_done;
  logic              overflow;
  logic [CW-1:0]     level;

  word_t sb[$];
  int    checks = 0;
  int    errors = 0;
  int    next_pix = 0;
  bit    exp_ovf = 1'b0;
  bit    exp_fd = 1'b0;

  cnn_result_collector #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .DEPTH  (T_DEPTH),
    .NPIX   (T_NPIX)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .result_en  (result_en),
    .result_vec (result_vec),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_lane   (out_lane),
    .out_pix    (out_pix),
    .out_last   (out_last),
    .frame_done (frame_done),
    .overflow   (overflow),
    .level      (level)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic result_vec_t makeVec(input logic [DATA_W-1:0] base);
    result_vec_t v;
    for (int k = 0; k < LANES; k++) v[k] = base + DATA_W'(k);
    return v;
  endfunction

  // Drive one cycle of inputs, check outputs against the scoreboard at the
  // falling edge, then advance the model by what this edge should do.
  task automatic applyStimulus(input bit en, input result_vec_t vec, input bit rdy);
    int lvl;
    bit valid_exp, xfer, popv, acc;
    result_en  = en;
    result_vec = vec;
    out_ready  = rdy;
    @(negedge clk);
    lvl       = (sb.size() + LANES - 1) / LANES;
    valid_exp = (sb.size() > 0);
    checkOutput("out_valid", out_valid, valid_exp);
    checkOutput("level", level, lvl);
    checkOutput("overflow", overflow, exp_ovf);
    checkOutput("frame_done", frame_done, exp_fd);
    if (valid_exp) begin
      checkOutput("out_data", out_data, sb[0].data);
      checkOutput("out_lane", out_lane, sb[0].lane);
      checkOutput("out_pix", out_pix, sb[0].pix);
      checkOutput("out_last", out_last, sb[0].last);
    end else begin
      checkOutput("out_last_idle", out_last, 0);
    end
    xfer = valid_exp && rdy;
    popv = xfer && (sb[0].lane == LANES - 1);
    acc  = en && (lvl < T_DEPTH || popv);
    if (en && !acc) exp_ovf = 1'b1;
    exp_fd = xfer && sb[0].last;
    if (xfer) void'(sb.pop_front());
    if (acc) begin
      for (int k = 0; k < LANES; k++) begin
        word_t w;
        w.data = vec[k];
        w.lane = k;
        w.pix  = next_pix;
        w.last = (k == LANES - 1) && (next_pix == T_NPIX - 1);
        sb.push_back(w);
      end
      next_pix = (next_pix == T_NPIX - 1) ? 0 : next_pix + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    result_en  = 1'b0;
    result_vec = '0;
    rst        = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    sb.delete();
    next_pix = 0;
    exp_ovf  = 1'b0;
    exp_fd   = 1'b0;
  endtask

  // Run with out_ready high until the scoreboard empties or the budget expires.
  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      applyStimulus(1'b0, '0, 1'b1);
      n++;
    end
    checkOutput("drain_budget", sb.size(), 0);
    applyStimulus(1'b0, '0, 1'b1);
  endtask

  initial begin
    rst        = 1'b1;
    result_en  = 1'b0;
    result_vec = '0;
    out_ready  = 1'b0;

    // Single vector drains in 16 words on pixel 0.
    doReset();
    checkOutput("reset_valid", out_valid, 0);
    checkOutput("reset_level", level, 0);
    checkOutput("reset_pix", out_pix, 0);
    checkOutput("reset_lane", out_lane, 0);
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b1, makeVec(32'h100), 1'b1);
    drain(40);
    checkOutput("single_level", level, 0);

    // Backpressure pattern 1,0,0,1 while draining pixel 1.
    applyStimulus(1'b1, makeVec(32'h200), 1'b0);
    for (int i = 0; i < 64; i++)
      applyStimulus(1'b0, '0, (i % 4 == 0) || (i % 4 == 3));
    drain(40);

    // Burst of 6 into a 4-deep FIFO with the stream stalled.
    doReset();
    for (int v = 0; v < 6; v++)
      applyStimulus(1'b1, makeVec(32'h300 + 32'h10 * v), 1'b0);
    checkOutput("burst_level", level, 4);
    checkOutput("burst_overflow", overflow, 1);
    drain(100);

    // Frame wrap: five vectors at the sustainable rate, fifth is pixel 0.
    doReset();
    for (int v = 0; v < 5; v++) begin
      applyStimulus(1'b1, makeVec(32'h500 + 32'h10 * v), 1'b1);
      repeat (15) applyStimulus(1'b0, '0, 1'b1);
    end
    drain(40);

    // Full FIFO with a vector arriving on the lane-15 transfer.
    doReset();
    for (int v = 0; v < 4; v++)
      applyStimulus(1'b1, makeVec(32'h700 + 32'h10 * v), 1'b0);
    repeat (15) applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b1, makeVec(32'h800), 1'b1);
    checkOutput("fullpop_level", level, 4);
    checkOutput("fullpop_overflow", overflow, 0);
    drain(100);

    // Reset at lane 7 of pixel 2 with two vectors buffered.
    doReset();
    for (int v = 0; v < 5; v++)
      applyStimulus(1'b1, makeVec(32'h900 + 32'h10 * v), 1'b0);
    repeat (39) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("mid_lane", out_lane, 7);
    checkOutput("mid_pix", out_pix, 2);
    checkOutput("mid_level", level, 2);
    doReset();
    checkOutput("rst_mid_valid", out_valid, 0);
    checkOutput("rst_mid_level", level, 0);
    checkOutput("rst_mid_overflow", overflow, 0);
    applyStimulus(1'b1, makeVec(32'hA00), 1'b1);
    checkOutput("rst_mid_new_pix", out_pix, 0);
    checkOutput("rst_mid_new_lane", out_lane, 0);
    drain(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
